// File: rtl/tile_draw_datapath_if.sv
// Control strobes from the graphics FSM (master) to the tile draw datapath (slave),
// plus the pixel stream and status flags flowing back.
interface tile_draw_datapath_if;
    logic       ld_tile;
    logic       ld_flash;
    logic       randomEnable;
    logic       writeEnable;
    logic       counterEnable;
    logic [2:0] tile_num;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       drw;
    logic [1:0] tile_sel;
    logic       overflow;

    modport master (
        output ld_tile, ld_flash, randomEnable, writeEnable, counterEnable, tile_num,
        input  x, y, colour, plot, drw, tile_sel, overflow
    );

    modport slave (
        input  ld_tile, ld_flash, randomEnable, writeEnable, counterEnable, tile_num,
        output x, y, colour, plot, drw, tile_sel, overflow
    );
endinterface

// File: rtl/tile_draw_datapath.sv
// Tile pixel engine: queues draw requests and sweeps one pixel per clock into the VGA adapter.
// Define TILE_FLASH_HOLD_EN to pause in HOLD for HOLD_CYCLES after every flash-colour sweep.
module tile_draw_datapath #(
    parameter int unsigned TILE_W      = 40,
    parameter int unsigned TILE_H      = 30,
    parameter int unsigned X_BASE      = 40,
    parameter int unsigned Y_BASE      = 30,
    parameter int unsigned QDEPTH      = 4,
    parameter int unsigned HOLD_CYCLES = 25_000_000
) (
    input  logic                clock,
    input  logic                reset,
    tile_draw_datapath_if.slave bus
);

    localparam int unsigned PW        = $clog2(QDEPTH);
    localparam logic [7:0]  X_ORG0    = 8'(X_BASE);
    localparam logic [7:0]  X_ORG1    = 8'(X_BASE + TILE_W);
    localparam logic [6:0]  Y_ORG0    = 7'(Y_BASE);
    localparam logic [6:0]  Y_ORG1    = 7'(Y_BASE + TILE_H);
    localparam logic [7:0]  COL_LAST  = 8'(TILE_W - 1);
    localparam logic [6:0]  ROW_LAST  = 7'(TILE_H - 1);
    localparam logic [PW:0] FIFO_FULL = (PW + 1)'(QDEPTH);

    if (QDEPTH < 4 || (QDEPTH & (QDEPTH - 1)) != 0 || TILE_W == 0 || TILE_H == 0 ||
        HOLD_CYCLES == 0) begin : g_bad_params
        $error("tile_draw_datapath: illegal parameter set");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_HOLD} state_t;

    state_t        state_q, state_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [2:0]    boot_cnt_q, boot_cnt_d;
    logic [1:0]    tile_sel_q, tile_sel_d;
    logic [2:0]    colour_reg_q, colour_reg_d;
    logic          overflow_q, overflow_d;
    logic [4:0]    fifo_mem_q [QDEPTH];
    logic [4:0]    fifo_mem_d [QDEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [7:0]    origin_x_q, origin_x_d;
    logic [6:0]    origin_y_q, origin_y_d;
    logic [2:0]    sweep_colour_q, sweep_colour_d;
    logic [7:0]    col_q, col_d;
    logic [6:0]    row_q, row_d;
    logic [7:0]    x_q, x_d;
    logic [6:0]    y_q, y_d;
    logic [2:0]    colour_q, colour_d;
    logic          plot_q, plot_d;
    logic          drw_q, drw_d;

    logic       lfsr_fb;
    logic       draw_req;
    logic       fifo_empty;
    logic       fifo_full;
    logic       push;
    logic       pop;
    logic [4:0] head;
    logic       last_pixel;

`ifdef TILE_FLASH_HOLD_EN
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic        hold_done;
    assign hold_done = (hold_cnt_q == 32'(HOLD_CYCLES - 1));
`endif

    function automatic logic [2:0] base_colour(input logic [1:0] tile);
        case (tile)
            2'd0:    return 3'b100;
            2'd1:    return 3'b010;
            2'd2:    return 3'b001;
            default: return 3'b110;
        endcase
    endfunction

    assign lfsr_fb    = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign draw_req   = bus.writeEnable & bus.counterEnable;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FIFO_FULL);
    // Fullness is judged before this cycle's pop, so a full FIFO drops even while draining.
    assign push       = draw_req & ~fifo_full;
    assign pop        = (state_q == ST_IDLE) & ~fifo_empty;
    assign head       = fifo_mem_q[rd_ptr_q];
    assign last_pixel = (col_q == COL_LAST) && (row_q == ROW_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                if (last_pixel) begin
`ifdef TILE_FLASH_HOLD_EN
                    state_d = (sweep_colour_q == 3'b111) ? ST_HOLD : ST_IDLE;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef TILE_FLASH_HOLD_EN
            ST_HOLD: begin
                if (hold_done) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        lfsr_d         = lfsr_q;
        boot_cnt_d     = boot_cnt_q;
        tile_sel_d     = tile_sel_q;
        colour_reg_d   = colour_reg_q;
        overflow_d     = overflow_q;
        fifo_mem_d     = fifo_mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        origin_x_d     = origin_x_q;
        origin_y_d     = origin_y_q;
        sweep_colour_d = sweep_colour_q;
        col_d          = col_q;
        row_d          = row_q;
        x_d            = x_q;
        y_d            = y_q;
        colour_d       = colour_q;
        plot_d         = 1'b0;

        if (bus.randomEnable) begin
            lfsr_d = {lfsr_q[6:0], lfsr_fb};
        end

        // During boot the FSM picks tiles explicitly; afterwards the LFSR picks them.
        if (bus.ld_tile) begin
            tile_sel_d   = (boot_cnt_q < 3'd4) ? bus.tile_num[1:0] : lfsr_q[1:0];
            colour_reg_d = base_colour(tile_sel_d);
        end
        if (bus.ld_flash) begin
            colour_reg_d = 3'b111;
        end

        if (draw_req && fifo_full) begin
            overflow_d = 1'b1;
        end
        if (push) begin
            fifo_mem_d[wr_ptr_q] = {tile_sel_q, colour_reg_q};
            wr_ptr_d             = wr_ptr_q + 1'b1;
            if (boot_cnt_q != 3'd4) begin
                boot_cnt_d = boot_cnt_q + 3'd1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        unique case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    origin_x_d     = head[3] ? X_ORG1 : X_ORG0;
                    origin_y_d     = head[4] ? Y_ORG1 : Y_ORG0;
                    sweep_colour_d = head[2:0];
                    col_d          = '0;
                    row_d          = '0;
                end
            end
            ST_SWEEP: begin
                plot_d   = 1'b1;
                x_d      = origin_x_q + col_q;
                y_d      = origin_y_q + row_q;
                colour_d = sweep_colour_q;
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = row_q + 7'd1;
                end else begin
                    col_d = col_q + 8'd1;
                end
            end
            default: begin
            end
        endcase

        drw_d = (state_q != ST_IDLE) || !fifo_empty;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q         <= 8'h01;
            boot_cnt_q     <= '0;
            tile_sel_q     <= '0;
            colour_reg_q   <= '0;
            overflow_q     <= 1'b0;
            fifo_mem_q     <= '{default: '0};
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            origin_x_q     <= '0;
            origin_y_q     <= '0;
            sweep_colour_q <= '0;
            col_q          <= '0;
            row_q          <= '0;
            x_q            <= '0;
            y_q            <= '0;
            colour_q       <= '0;
            plot_q         <= 1'b0;
            drw_q          <= 1'b0;
        end else begin
            lfsr_q         <= lfsr_d;
            boot_cnt_q     <= boot_cnt_d;
            tile_sel_q     <= tile_sel_d;
            colour_reg_q   <= colour_reg_d;
            overflow_q     <= overflow_d;
            fifo_mem_q     <= fifo_mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            origin_x_q     <= origin_x_d;
            origin_y_q     <= origin_y_d;
            sweep_colour_q <= sweep_colour_d;
            col_q          <= col_d;
            row_q          <= row_d;
            x_q            <= x_d;
            y_q            <= y_d;
            colour_q       <= colour_d;
            plot_q         <= plot_d;
            drw_q          <= drw_d;
        end
    end

`ifdef TILE_FLASH_HOLD_EN
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (state_q == ST_HOLD) begin
            hold_cnt_d = hold_done ? 32'd0 : hold_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`endif

    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.colour   = colour_q;
    assign bus.plot     = plot_q;
    assign bus.drw      = drw_q;
    assign bus.tile_sel = tile_sel_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_tile_draw_datapath.sv
// Directed bench for tile_draw_datapath using a 4x2 tile so every plotted pixel
// can be checked against hand-derived positions, colours and cycle numbers.
`timescale 1ns/1ps
module tb_tile_draw_datapath;

    localparam int TW   = 4;
    localparam int TH   = 2;
    localparam int XB   = 40;
    localparam int YB   = 30;
    localparam int QD   = 4;
    localparam int HOLD = 10;
    localparam int NPIX = TW * TH;
`ifdef TILE_FLASH_HOLD_EN
    localparam int HOLD_EXTRA = HOLD;
`else
    localparam int HOLD_EXTRA = 0;
`endif

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   edges    = 0;

    int   px[$];
    int   py[$];
    int   pc[$];
    int   pe[$];
    int   drw_rise  = -1;
    int   drw_fall  = -1;
    int   drw_rises = 0;
    logic drw_prev  = 1'b0;

    logic [2:0] base_tab [4] = '{3'b100, 3'b010, 3'b001, 3'b110};

    tile_draw_datapath_if bus ();

    tile_draw_datapath #(
        .TILE_W      (TW),
        .TILE_H      (TH),
        .X_BASE      (XB),
        .Y_BASE      (YB),
        .QDEPTH      (QD),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edges <= edges + 1;

    // Pixel log and drw transitions, sampled mid-cycle.
    always @(negedge clock) begin
        if (bus.plot === 1'b1) begin
            px.push_back(int'(bus.x));
            py.push_back(int'(bus.y));
            pc.push_back(int'(bus.colour));
            pe.push_back(edges);
        end
        if (bus.drw === 1'b1 && !drw_prev) begin
            drw_rise  = edges;
            drw_rises = drw_rises + 1;
        end
        if (bus.drw !== 1'b1 && drw_prev) begin
            drw_fall = edges;
        end
        drw_prev = (bus.drw === 1'b1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic lt, input logic lf, input logic re,
                                 input logic we, input logic ce, input logic [2:0] tn);
        bus.ld_tile       = lt;
        bus.ld_flash      = lf;
        bus.randomEnable  = re;
        bus.writeEnable   = we;
        bus.counterEnable = ce;
        bus.tile_num      = tn;
        @(negedge clock);
        bus.ld_tile       = 1'b0;
        bus.ld_flash      = 1'b0;
        bus.randomEnable  = 1'b0;
        bus.writeEnable   = 1'b0;
        bus.counterEnable = 1'b0;
        bus.tile_num      = 3'd0;
    endtask

    task automatic clearLog();
        px.delete();
        py.delete();
        pc.delete();
        pe.delete();
        drw_rise  = -1;
        drw_fall  = -1;
        drw_rises = 0;
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n = 0;
        repeat (2) @(negedge clock);
        while (bus.drw !== 1'b0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        checkOutput({tag, " idle within budget"}, (n < budget), 1);
        @(negedge clock);
    endtask

    function automatic int lastEdge();
        return (pe.size() > 0) ? pe[pe.size() - 1] : -1000;
    endfunction

    task automatic checkSweep(input string tag, input int first, input int tile,
                              input int colour);
        for (int p = 0; p < NPIX; p++) begin
            int idx = first + p;
            if (idx < px.size()) begin
                checkOutput($sformatf("%s px%0d x", tag, idx), px[idx],
                            XB + (tile % 2) * TW + p % TW);
                checkOutput($sformatf("%s px%0d y", tag, idx), py[idx],
                            YB + (tile / 2) * TH + p / TW);
                checkOutput($sformatf("%s px%0d colour", tag, idx), pc[idx], colour);
                if (p > 0) begin
                    checkOutput($sformatf("%s px%0d edge", tag, idx), pe[idx], pe[idx - 1] + 1);
                end
            end
        end
    endtask

    initial begin
        int t0;
        int n;
        int k;
        int logged;

        reset             = 1'b1;
        bus.ld_tile       = 1'b0;
        bus.ld_flash      = 1'b0;
        bus.randomEnable  = 1'b0;
        bus.writeEnable   = 1'b0;
        bus.counterEnable = 1'b0;
        bus.tile_num      = 3'd0;
        repeat (3) @(negedge clock);

        checkOutput("reset x", bus.x, 0);
        checkOutput("reset y", bus.y, 0);
        checkOutput("reset colour", bus.colour, 0);
        checkOutput("reset plot", bus.plot, 0);
        checkOutput("reset drw", bus.drw, 0);
        checkOutput("reset tile_sel", bus.tile_sel, 0);
        checkOutput("reset overflow", bus.overflow, 0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("post reset drw", bus.drw, 0);

        // Boot burst: ld_tile then draw for tiles 0..3.
        clearLog();
        for (int t = 0; t < 4; t++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'(t));
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
        end
        waitIdle("boot", 200);
        checkOutput("boot plot count", px.size(), 4 * NPIX);
        for (int t = 0; t < 4; t++) begin
            checkSweep($sformatf("boot t%0d", t), t * NPIX, t, int'(base_tab[t]));
        end
        checkOutput("boot drw single rise", drw_rises, 1);
        checkOutput("boot drw fall", drw_fall, lastEdge() + 1);
        checkOutput("boot overflow", bus.overflow, 0);
        checkOutput("boot tile_sel", bus.tile_sel, 3);

        // Single sweep with timing; writeEnable alone must not draw.
        clearLog();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        repeat (3) @(negedge clock);
        checkOutput("we alone drw", bus.drw, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
        t0 = edges;
        checkOutput("single drw at pulse edge", bus.drw, 0);
        waitIdle("single", 100);
        checkOutput("single plot count", px.size(), NPIX);
        checkOutput("single first plot edge", (pe.size() > 0) ? pe[0] : -1, t0 + 2);
        checkOutput("single last plot edge", lastEdge(), t0 + 1 + NPIX);
        checkOutput("single drw rise", drw_rise, t0 + 1);
        checkOutput("single drw fall", drw_fall, lastEdge() + 1);
        checkSweep("single", 0, 3, 3'b110);

        // LFSR: 01 -> 02 -> 04 -> 08, then 08 -> 11.
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
        checkOutput("lfsr 08 tile_sel", bus.tile_sel, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
        checkOutput("lfsr 11 tile_sel", bus.tile_sel, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        checkOutput("lfsr frozen tile_sel", bus.tile_sel, 1);

        // Flash, with a draw in the same cycle as ld_tile capturing the flash colour.
        clearLog();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
        waitIdle("flash", 100);
        checkOutput("flash plot count", px.size(), NPIX);
        checkSweep("flash", 0, 1, 3'b111);
        checkOutput("flash drw fall", drw_fall, lastEdge() + 1 + HOLD_EXTRA);
        clearLog();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
        waitIdle("reload", 100);
        checkOutput("reload plot count", px.size(), NPIX);
        checkSweep("reload", 0, 1, 3'b010);

        // Overflow: five back-to-back pulses fit, a sixth with four queued is dropped.
        clearLog();
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
        checkOutput("overflow after 5", bus.overflow, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
        checkOutput("overflow after 6", bus.overflow, 1);
        waitIdle("overflow", 200);
        checkOutput("overflow plot count", px.size(), 5 * NPIX);
        checkSweep("overflow first", 0, 1, 3'b010);
        checkSweep("overflow last", 4 * NPIX, 1, 3'b010);
        checkOutput("overflow bubble", (pe.size() > NPIX) ? pe[NPIX] - pe[NPIX - 1] : -1, 2);
        checkOutput("overflow sticky", bus.overflow, 1);

        // Reset in the middle of a sweep with more entries queued.
        clearLog();
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
        n = 0;
        k = 0;
        while (n < 5 && k < 50) begin
            @(negedge clock);
            if (bus.plot === 1'b1) n++;
            k++;
        end
        checkOutput("reset reached mid sweep", n, 5);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midreset plot", bus.plot, 0);
        checkOutput("midreset drw", bus.drw, 0);
        checkOutput("midreset x", bus.x, 0);
        checkOutput("midreset y", bus.y, 0);
        checkOutput("midreset overflow", bus.overflow, 0);
        reset = 1'b0;
        @(negedge clock);
        logged = px.size();
        repeat (12) @(negedge clock);
        checkOutput("midreset flushed drw", bus.drw, 0);
        checkOutput("midreset no more plots", px.size(), logged);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
